// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, FSM state encoding and
// instruction field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RA_LSB = 4;
  localparam int RB_LSB = 0;

endpackage

// File: rtl/cpu_regfile.sv
// NREGS x DW register file: two combinational read ports, one synchronous
// write port, asynchronous clear to zero.
module cpu_regfile #(
  parameter  int DW    = 16,
  parameter  int NREGS = 16,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [RW-1:0] raddr_a,
  input  logic [RW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu_multicycle.sv
// Parametrised multi-cycle CPU: program load through an auto-incrementing IM
// write port, then FETCH/DECODE/EXEC execution with compare flags and a write-back monitor.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter  int DW       = 16,
  parameter  int NREGS    = 16,
  parameter  int IM_DEPTH = 256,
  parameter  int SIGNED   = 0,
  localparam int AW       = $clog2(IM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we_IM,
  input  logic [31:0]   codein,
  input  logic [11:0]   immd,
  output logic          za,
  output logic          zb,
  output logic          eq,
  output logic          gt,
  output logic          lt,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          wb_valid,
  output logic [DW-1:0] wb_data,
  output state_t        dbg_state
);

  localparam int RW = $clog2(NREGS);
  localparam int TW = (AW < 12) ? AW : 12;

  // Handshake: none. en is a level run/pause enable sampled every cycle; we_IM
  // is a one-word-per-cycle write strobe honoured only in IDLE; wb_valid is a
  // single-cycle pulse qualifying wb_data.

  state_t        state;
  logic [31:0]   im [IM_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [31:0]   ir;
  logic [DW-1:0] a_q, b_q;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [DW-1:0] alu_res;
  logic          cmp_eq, cmp_gt, cmp_lt;
  logic          take_jump;
  logic          is_wb;
  logic          rf_we;
  logic [AW-1:0] jmp_tgt;
  logic [3:0]    op;
  logic [RW-1:0] rd, ra, rb;
  logic          unused_ir;

  assign op        = ir[OP_LSB +: 4];
  assign rd        = ir[RD_LSB +: RW];
  assign ra        = ir[RA_LSB +: RW];
  assign rb        = ir[RB_LSB +: RW];
  assign jmp_tgt   = AW'(ir[TW-1:0]);
  assign unused_ir = ^ir[31:16];
  assign dbg_state = state;

  cpu_regfile #(.DW(DW), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (alu_res),
    .raddr_a (ra),
    .raddr_b (rb),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // Instruction memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (rst_n && state == S_IDLE && we_IM) im[wr_ptr] <= codein;
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_MOV:  alu_res = a_q;
      OP_LDI:  alu_res = DW'(immd);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    cmp_eq = (a_q == b_q);
    if (SIGNED != 0) cmp_gt = ($signed(a_q) > $signed(b_q));
    else             cmp_gt = (a_q > b_q);
    cmp_lt = !cmp_eq && !cmp_gt;
  end

  assign is_wb     = (op >= OP_ADD) && (op <= OP_LDI);
  assign rf_we     = (state == S_EXEC) && en && is_wb;
  assign take_jump = (op == OP_JMP) || (op == OP_BEQ && eq) || (op == OP_BNE && !eq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= '0;
      wr_ptr   <= '0;
      ir       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      za       <= 1'b0;
      zb       <= 1'b0;
      eq       <= 1'b0;
      gt       <= 1'b0;
      lt       <= 1'b0;
      halted   <= 1'b0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (we_IM) begin
            wr_ptr <= wr_ptr + 1'b1;
          end else if (en) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (en) begin
            ir    <= im[pc];
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (en) begin
            a_q   <= rdata_a;
            b_q   <= rdata_b;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (en) begin
            if (is_wb) begin
              wb_valid <= 1'b1;
              wb_data  <= alu_res;
            end
            if (op == OP_CMP) begin
              za <= (a_q == '0);
              zb <= (b_q == '0);
              eq <= cmp_eq;
              gt <= cmp_gt;
              lt <= cmp_lt;
            end
            if (op == OP_HALT) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state <= S_FETCH;
              pc    <= take_jump ? jmp_tgt : pc + 1'b1;
            end
          end
        end
        S_HALT: begin
          // Dropping en returns to IDLE so a reload starts again at address 0.
          if (!en) begin
            state  <= S_IDLE;
            halted <= 1'b0;
            wr_ptr <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: default, signed-compare and 4-word-IM instances.
module tb_cpu_multicycle;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for the default and signed instances
  logic        en = 1'b0, we_IM = 1'b0;
  logic [31:0] codein = '0;
  logic [11:0] immd = '0;
  logic        za, zb, eq, gt, lt, halted, wb_valid;
  logic [7:0]  pc;
  logic [15:0] wb_data;
  state_t      st;
  logic        za_s, zb_s, eq_s, gt_s, lt_s, halted_s, wb_valid_s;
  logic [7:0]  pc_s;
  logic [15:0] wb_data_s;
  state_t      st_s;

  // stimulus for the IM_DEPTH=4 instance
  logic        en4 = 1'b0, we4 = 1'b0;
  logic [31:0] code4 = '0;
  logic [11:0] immd4 = 12'h5A5;
  logic        za4, zb4, eq4, gt4, lt4, halted4, wb_valid4;
  logic [1:0]  pc4;
  logic [15:0] wb_data4;
  state_t      st4;

  cpu_multicycle dut (
    .clk(clk), .rst_n(rst_n), .en(en), .we_IM(we_IM), .codein(codein), .immd(immd),
    .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt), .pc(pc), .halted(halted),
    .wb_valid(wb_valid), .wb_data(wb_data), .dbg_state(st)
  );

  cpu_multicycle #(.SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .we_IM(we_IM), .codein(codein), .immd(immd),
    .za(za_s), .zb(zb_s), .eq(eq_s), .gt(gt_s), .lt(lt_s), .pc(pc_s), .halted(halted_s),
    .wb_valid(wb_valid_s), .wb_data(wb_data_s), .dbg_state(st_s)
  );

  cpu_multicycle #(.IM_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .we_IM(we4), .codein(code4), .immd(immd4),
    .za(za4), .zb(zb4), .eq(eq4), .gt(gt4), .lt(lt4), .pc(pc4), .halted(halted4),
    .wb_valid(wb_valid4), .wb_data(wb_data4), .dbg_state(st4)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  logic [11:0] imm_tab [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    en = 1'b0; we_IM = 1'b0; en4 = 1'b0; we4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) imm_tab[i] = '0;
    exp_q.delete();
  endtask

  task automatic put(input logic [15:0] w);
    logic [15:0] hi;
    hi = 16'($urandom_range(0, 16'hFFFF));
    we_IM = 1'b1;
    codein = {hi, w};
    @(negedge clk);
    we_IM = 1'b0;
  endtask

  task automatic put4(input logic [15:0] w);
    we4 = 1'b1;
    code4 = {16'h0000, w};
    @(negedge clk);
    we4 = 1'b0;
  endtask

  // Runs the loaded program until HALT; immd follows pc like an external table.
  task automatic run(input bit do_pause, input logic [7:0] pause_pc);
    bit paused = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 400 && !halted; c++) begin
      @(negedge clk);
      immd = imm_tab[pc];
      if (wb_valid) begin
        if (exp_q.size() == 0) check("wb_unexpected", 32'(exp_q.size()), 1);
        else check("wb_data", 32'(wb_data), 32'(exp_q.pop_front()));
      end
      if (do_pause && !paused && st == S_DECODE && pc == pause_pc) begin
        paused = 1'b1;
        en = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("pause_pc", 32'(pc), 32'(pause_pc));
          check("pause_state", 32'(st), 32'(S_DECODE));
          check("pause_wb", 32'(wb_valid), 0);
        end
        en = 1'b1;
      end
    end
    check("halted", 32'(halted), 1);
    check("wb_missing", 32'(exp_q.size()), 0);
  endtask

  initial begin
    do_reset();
    // reset state
    check("rst_pc", 32'(pc), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_flags", {27'd0, za, zb, eq, gt, lt}, 0);
    check("rst_wb", {15'd0, wb_valid, wb_data}, 0);
    check("rst_state", 32'(st), 32'(S_IDLE));
    check("rst_pc4", 32'(pc4), 0);

    // 1: LDI/LDI/ADD/HALT
    put(16'h7011); put(16'h7102); put(16'h1201); put(16'hF000);
    imm_tab[0] = 12'hFEB; imm_tab[1] = 12'h003;
    exp_q.push_back(16'h0FEB); exp_q.push_back(16'h0003); exp_q.push_back(16'h0FEE);
    run(1'b0, 8'd0);
    check("t1_pc", 32'(pc), 3);
    check("t1_flags", {29'd0, eq, gt, lt}, 0);
    en = 1'b0;
    @(negedge clk);
    check("t1_idle", 32'(halted), 0);
    check("t1_idle_state", 32'(st), 32'(S_IDLE));

    // 2a: CMP 5 vs 9
    do_reset();
    put(16'h7100); put(16'h7200); put(16'h8012); put(16'hF000);
    imm_tab[0] = 12'd5; imm_tab[1] = 12'd9;
    exp_q.push_back(16'd5); exp_q.push_back(16'd9);
    run(1'b0, 8'd0);
    check("t2_flags", {27'd0, za, zb, eq, gt, lt}, 5'b00001);
    check("t2_flags_s", {27'd0, za_s, zb_s, eq_s, gt_s, lt_s}, 5'b00001);
    en = 1'b0;
    @(negedge clk);
    check("t2_hold", {27'd0, za, zb, eq, gt, lt}, 5'b00001);

    // 2b: CMP 0 vs 0
    do_reset();
    put(16'h8012); put(16'hF000);
    run(1'b0, 8'd0);
    check("t2b_flags", {27'd0, za, zb, eq, gt, lt}, 5'b11100);

    // 3: FFFF vs 0001, unsigned and signed
    do_reset();
    put(16'h7100); put(16'h7201); put(16'h2112); put(16'h8012); put(16'hF000);
    imm_tab[0] = 12'd0; imm_tab[1] = 12'd1;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001); exp_q.push_back(16'hFFFF);
    run(1'b0, 8'd0);
    check("t3_unsigned", {27'd0, za, zb, eq, gt, lt}, 5'b00010);
    check("t3_signed", {27'd0, za_s, zb_s, eq_s, gt_s, lt_s}, 5'b00001);

    // 4: countdown loop with BNE
    do_reset();
    put(16'h7000); put(16'h7100); put(16'h2001); put(16'h8002); put(16'hB002); put(16'hF000);
    imm_tab[0] = 12'd3; imm_tab[1] = 12'd1;
    exp_q.push_back(16'd3); exp_q.push_back(16'd1);
    exp_q.push_back(16'd2); exp_q.push_back(16'd1); exp_q.push_back(16'd0);
    run(1'b0, 8'd0);
    check("t4_pc", 32'(pc), 5);
    check("t4_flags", {27'd0, za, zb, eq, gt, lt}, 5'b11100);

    // 5: pause in DECODE of the second instruction
    do_reset();
    put(16'h7011); put(16'h7102); put(16'h1201); put(16'hF000);
    imm_tab[0] = 12'hFEB; imm_tab[1] = 12'h003;
    exp_q.push_back(16'h0FEB); exp_q.push_back(16'h0003); exp_q.push_back(16'h0FEE);
    run(1'b1, 8'd1);
    check("t5_pc", 32'(pc), 3);

    // 6: 4-word IM: overwrite, pc wrap, reset mid-EXEC
    do_reset();
    put4(16'hF000); put4(16'h0000); put4(16'h0000); put4(16'h0000); put4(16'h7000);
    begin
      int pulses = 0;
      bit wrapped = 1'b0;
      bit found = 1'b0;
      logic [1:0] prev_pc = 2'd0;
      en4 = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (wb_valid4) begin
          pulses++;
          check("t6_wb", 32'(wb_data4), 32'h05A5);
        end
        if (prev_pc == 2'd3 && pc4 == 2'd0) wrapped = 1'b1;
        prev_pc = pc4;
      end
      check("t6_pulses", 32'(pulses), 2);
      check("t6_wrap", 32'(wrapped), 1);
      check("t6_not_halted", 32'(halted4), 0);
      for (int c = 0; c < 30 && !found; c++) begin
        @(negedge clk);
        if (st4 == S_EXEC && pc4 == 2'd0) found = 1'b1;
      end
      check("t6_exec_wait", 32'(found), 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_pc", 32'(pc4), 0);
      check("t6_rst_state", 32'(st4), 32'(S_IDLE));
      check("t6_rst_out", {26'd0, za4, zb4, eq4, gt4, lt4, halted4}, 0);
      check("t6_rst_wb", {15'd0, wb_valid4, wb_data4}, 0);
      @(negedge clk);
      check("t6_rst_nowb", 32'(wb_valid4), 0);
      check("t6_rst_pc_main", 32'(pc), 0);
      en4 = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
